// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the A/B channels, decodes Gray-code steps
// into a wrapping position count with up/down strobes, and flags illegal
// double-bit transitions with a sticky error bit.
module quad_decoder #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clr,
  input  logic         a_in,
  input  logic         b_in,
  output logic [N-1:0] q,
  output logic         up_pulse,
  output logic         dn_pulse,
  output logic         err
);

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [1:0]   sync1_q, sync2_q, prev_q;
  logic [0:0]   state_q, state_d;
  logic [1:0]   init_cnt_q, init_cnt_d;
  logic [N-1:0] q_q, q_d;
  logic         up_q, up_d;
  logic         dn_q, dn_d;
  logic         err_q, err_d;
  logic         step_up, step_dn, step_bad;

  // Two-flop synchronizer for both channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {a_in, b_in};
      sync2_q <= sync1_q;
    end
  end

  // Previous sample follows the synchronized value every cycle, INIT included,
  // so the first TRACK cycle compares against a real sample, not the reset 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync2_q;
    end
  end

  // Classify the transition prev -> cur.
  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    step_bad = 1'b0;
    unique case ({prev_q, sync2_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up  = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
      default: ;
    endcase
  end

  // INIT spans three edges after reset release, then TRACK until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      if (init_cnt_q == 2'd2) begin
        state_d = TRACK;
      end else begin
        init_cnt_d = init_cnt_q + 2'd1;
      end
    end
  end

  // Count, strobe and error next-state; clr overrides any step in TRACK.
  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    if (state_q == TRACK) begin
      if (clr) begin
        q_d   = '0;
        err_d = 1'b0;
      end else if (enable) begin
        if (step_up) begin
          q_d  = q_q + N'(1);
          up_d = 1'b1;
        end else if (step_dn) begin
          q_d  = q_q - N'(1);
          dn_d = 1'b1;
        end else if (step_bad) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      q_q        <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      q_q        <= q_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      err_q      <= err_d;
    end
  end

  assign q        = q_q;
  assign up_pulse = up_q;
  assign dn_pulse = dn_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios with literal
// expectations plus randomized Gray/illegal stepping against a phase model.
`timescale 1ns/1ps
module tb_quad_decoder;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         clr;
  logic         a_in, b_in;
  logic [N-1:0] q;
  logic         up_pulse, dn_pulse, err;

  int checks   = 0;
  int failures = 0;
  int upcnt    = 0;
  int dncnt    = 0;

  quad_decoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clr      (clr),
    .a_in     (a_in),
    .b_in     (b_in),
    .q        (q),
    .up_pulse (up_pulse),
    .dn_pulse (dn_pulse),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position of an AB pair along the forward Gray cycle 00,01,11,10.
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: at edge t (counted from reset release) the decoder sees
  // the input sampled two edges ago against the one sampled three edges ago;
  // edges 1..3 are absorbed by initialisation.
  int         m_edges;
  logic [1:0] m_h1, m_h2, m_h3;
  int         m_q;
  logic       m_up, m_dn, m_err;

  always @(posedge clk or posedge rst) begin
    int d;
    if (rst) begin
      m_edges = 0;
      m_h1 = 2'b00; m_h2 = 2'b00; m_h3 = 2'b00;
      m_q = 0; m_up = 0; m_dn = 0; m_err = 0;
    end else begin
      if (m_edges < 10) m_edges++;
      m_up = 0;
      m_dn = 0;
      if (m_edges >= 4) begin
        d = (phase(m_h2) - phase(m_h3) + 4) % 4;
        if (clr) begin
          m_q = 0;
          m_err = 0;
        end else if (enable) begin
          if (d == 1) begin m_q = (m_q + 1) % (1 << N); m_up = 1; end
          else if (d == 3) begin m_q = (m_q + (1 << N) - 1) % (1 << N); m_dn = 1; end
          else if (d == 2) m_err = 1;
        end
      end
      m_h3 = m_h2;
      m_h2 = m_h1;
      m_h1 = {a_in, b_in};
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("q", int'(q), m_q);
    chk("up_pulse", int'(up_pulse), int'(m_up));
    chk("dn_pulse", int'(dn_pulse), int'(m_dn));
    chk("err", int'(err), int'(m_err));
    chk("pulse_exclusive", int'(up_pulse & dn_pulse), 0);
    if (up_pulse) upcnt++;
    if (dn_pulse) dncnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    {a_in, b_in} = v;
    tick(n);
  endtask

  task automatic do_reset(input logic [1:0] v);
    rst = 1'b1;
    {a_in, b_in} = v;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ub, db, p;
    logic [1:0] ab;
    rst = 1'b1; enable = 1'b1; clr = 1'b0; a_in = 1'b1; b_in = 1'b1;

    // Reset release with AB=11 held: INIT absorbs it.
    tick(1);
    chk("reset_q", int'(q), 0);
    chk("reset_err", int'(err), 0);
    ub = upcnt; db = dncnt;
    do_reset(2'b11);
    tick(8);
    chk("init11_q", int'(q), 0);
    chk("init11_err", int'(err), 0);
    chk("init11_pulses", (upcnt - ub) + (dncnt - db), 0);

    // Four forward steps, four single-cycle strobes.
    do_reset(2'b00);
    tick(6);
    ub = upcnt;
    drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4); drive(2'b00, 4);
    chk("fwd4_q", int'(q), 4);
    chk("fwd4_upcnt", upcnt - ub, 4);

    // Clear, one reverse step wraps to 15, 16 forward steps return to 15.
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    chk("clr_q", int'(q), 0);
    db = dncnt;
    drive(2'b10, 4);
    chk("wrap_dn_q", int'(q), 15);
    chk("wrap_dn_cnt", dncnt - db, 1);
    p = 3;
    for (int i = 0; i < 16; i++) begin
      p++;
      drive(ab_of(p), 2);
    end
    tick(2);
    chk("wrap_up_q", int'(q), 15);

    // Illegal 10->01 sets sticky err; legal steps keep it; clr clears.
    drive(2'b01, 4);
    chk("illegal_q", int'(q), 15);
    chk("illegal_err", int'(err), 1);
    drive(2'b11, 3); drive(2'b10, 4);
    chk("sticky_q", int'(q), 1);
    chk("sticky_err", int'(err), 1);
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    chk("clr_err", int'(err), 0);
    chk("clr_q2", int'(q), 0);

    // Disabled steps are not counted, nor replayed on re-enable.
    ub = upcnt; db = dncnt;
    enable = 1'b0;
    drive(2'b00, 3); drive(2'b01, 3); drive(2'b11, 3);
    enable = 1'b1;
    tick(4);
    chk("dis_q", int'(q), 0);
    chk("dis_pulses", (upcnt - ub) + (dncnt - db), 0);
    drive(2'b10, 4);
    chk("reen_q", int'(q), 1);

    // clr on the edge that would count a forward step.
    drive(2'b00, 4); drive(2'b01, 4);
    chk("pre_clr_q", int'(q), 3);
    {a_in, b_in} = 2'b11;
    tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_step_q", int'(q), 0);
    chk("clr_step_up", int'(up_pulse), 0);
    tick(2);
    p = 2;
    for (int i = 0; i < 7; i++) begin
      p++;
      drive(ab_of(p), 4);
    end
    chk("seven_q", int'(q), 7);

    // Asynchronous reset mid-count.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_err", int'(err), 0);
    tick(2);
    rst = 1'b0;

    // Randomized stepping.
    ab = {a_in, b_in};
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30)      ab = ab_of(phase(ab) + 1);
      else if (r < 60) ab = ab_of(phase(ab) + 3);
      else if (r < 64) ab = ~ab;
      {a_in, b_in} = ab;
      enable = ($urandom_range(0, 99) < 80);
      clr    = ($urandom_range(0, 99) < 3);
      if (i == 1500) begin
        rst = 1'b1; tick(2); rst = 1'b0;
      end
      tick(1);
    end
    clr = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
